idli_sqi_xfer_m: RTL
====================

Name: idli_sqi_xfer_m

Overview:
Parametrised SQI transaction engine, the successor to the fixed 16b single-chip SQI controller. It has its own nibble sequencer instead of an external 4-cycle counter. It accepts parallel word requests from the core with a valid/ready handshake, drives CMD/ADDR/DUMMY/DATA phases to one of NUM_CS quad-SPI SRAMs, and keeps the memory streaming across sequential requests. When no request is pending it holds the transaction with SCK gated instead of restarting it. It sits between the core's memory unit and the chip pins.

Parameters:
ADDR_W, 16, address width in bits; multiple of 4, range 8..32.
DATA_W, 16, word width in bits; multiple of 8.
DUMMY_CYC, 2, SCK cycles of dummy after the address, read only.
NUM_CS, 2, number of chip selects (memories).
CS_HI_CYC, 2, minimum cycles CS is held deasserted before a new command.

Ports:
i_sqi_gck  in  1  clock; SCK is derived from it.
i_sqi_rst  in  1  asynchronous, active-high reset.
i_req_vld  in  1  request valid.
o_req_rdy  out  1  request ready; a request is accepted when vld & rdy.
i_req_rd  in  1  1 = read, 0 = write.
i_req_cs  in  CSW = max(1, clog2(NUM_CS))  target chip index.
i_req_addr  in  ADDR_W  byte address.
i_req_wdata  in  DATA_W  write word, little endian.
i_req_end  in  1  close a held transaction (from HOLD only).
o_rd_vld  out  1  one-cycle pulse; read word valid.
o_rd_data  out  DATA_W  read word, little endian.
o_busy  out  1  state != IDLE.
o_sqi_sck  out  1  gated memory clock.
o_sqi_cs_n  out  NUM_CS  per-chip select; 1 = deselected.
o_sqi_mode  out  sqi_mode_t  pin direction, SQI_MODE_IN or SQI_MODE_OUT.
o_sqi_wr_data  out  4  nibble driven to memory.
i_sqi_rd_data  in  4  nibble from memory.

Behaviour:
- States and phase lengths:
  - IDLE.
  - CS_HI: CS_HI_CYC cycles.
  - CMD: 2 cycles; nibbles 0x0, then 0x3 (read) or 0x2 (write).
  - ADDR: ADDR_W/4 cycles, most significant nibble first.
  - DUMMY: DUMMY_CYC cycles; reads only, writes skip it.
  - DATA: DATA_W/4 cycles.
  - HOLD.
- The state and the nibble counter are registered; the counter resets on every state entry.
- Reset (async): state = IDLE, all o_sqi_cs_n = 1, o_sqi_mode = IN, o_sqi_wr_data = 0, o_rd_vld = 0, o_rd_data = 0, o_req_rdy = 1, o_sqi_sck = 0. Reset during any phase aborts immediately with no read pulse.
- o_req_rdy = 1 in IDLE, in HOLD, and on the last DATA cycle. It is 0 otherwise.
- IDLE + accept: latch rd, cs, addr and wdata, then go to CS_HI.
- Last DATA cycle, or HOLD, with accept and a sequential request:
  - Sequential means same rd, same cs, and addr == next_addr, where next_addr = prev_addr + DATA_W/8 mod 2^ADDR_W. Wrap to 0 counts as sequential.
  - Go straight to DATA with no command resend and no gap cycle.
- Same points, accept but non-sequential: raise CS and go to CS_HI with the new request latched.
- Last DATA cycle with no accept: go to HOLD. In HOLD, CS stays low, SCK is gated off, and mode is unchanged.
- HOLD + i_req_end with no accept: go to IDLE and raise CS. If accept and i_req_end are both high, the accept wins.
- CS: o_sqi_cs_n[cs] = 0 in CMD, ADDR, DUMMY, DATA and HOLD. All other bits, and every bit in IDLE and CS_HI, are 1.
- SCK: o_sqi_sck = i_sqi_gck & sck_en. sck_en is 1 in CMD, ADDR, DUMMY and DATA.
  - sck_en is computed from the registered state and updated through a latch transparent while gck is low, so SCK is glitch-free.
- Mode: OUT in CMD, ADDR, and write DATA/HOLD. IN everywhere else. o_sqi_wr_data = 0 whenever mode is IN.
- Data byte order:
  - Memory is big endian per byte; lowest address first, high nibble of each byte first.
  - Core words are little endian, so nibble order on the pins is [7:4],[3:0],[15:12],[11:8],...
  - Write nibbles follow this order; read nibbles are reassembled into it.
- Read capture: sample i_sqi_rd_data on each posedge in read DATA. o_rd_vld pulses with o_rd_data on the cycle after the last nibble is sampled. o_rd_data holds until the next pulse.
- Latency at defaults, counted in cycles after accept:
  - Read: CS_HI 2 + CMD 2 + ADDR 4 + DUMMY 2 + DATA 4 = 14 cycles, with o_rd_vld on cycle 15.
  - Sequential read: o_rd_vld every 4 cycles.

Test Plan:
1. Reset, then read cs=1 addr 0x1234, memory returns nibbles 3,4,1,2 → CMD 0,3; ADDR 1,2,3,4; cs_n = 2'b01; 2 dummy SCK; o_rd_data = 0x1234 (bits [7:4]=3, [3:0]=4, [15:12]=1, [11:8]=2) on cycle 15.
2. Write addr 0x0010, wdata 0xBEEF → CMD 0,2; ADDR 0,0,1,0; no dummy; DATA nibbles E,F,B,E; mode OUT throughout.
3. Back-to-back sequential reads 0x0100, 0x0102, 0x0104 → one CMD/ADDR only; o_rd_vld pulses exactly 4 cycles apart; CS never rises.
4. Read at 0xFFFE, then a sequential request at 0x0000 arriving 3 cycles late → 3 HOLD cycles with SCK low and CS low; resume without a command; second word correct.
5. HOLD, then a write request to the same cs → CS high for 2 cycles, full CMD/ADDR; HOLD + i_req_end → IDLE, cs_n = all 1, mode IN.
6. Assert i_sqi_rst mid-ADDR → same-cycle cs_n = all 1, SCK 0, no o_rd_vld; a subsequent read completes normally.

Source files
------------

// File: rtl/idli_sqi_xfer_m.sv
// SQI transaction engine: streams CMD/ADDR/DUMMY/DATA nibbles to one of NUM_CS
// quad-SPI SRAMs and keeps sequential word requests in one open transaction.

package idli_sqi_pkg;
    typedef enum logic {
        SQI_MODE_IN  = 1'b0,
        SQI_MODE_OUT = 1'b1
    } sqi_mode_t;
endpackage

module idli_sqi_xfer_m
    import idli_sqi_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DUMMY_CYC = 2,
    parameter int unsigned NUM_CS    = 2,
    parameter int unsigned CS_HI_CYC = 2,
    localparam int unsigned CSW      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              i_sqi_gck,
    input  logic              i_sqi_rst,
    input  logic              i_req_vld,
    output logic              o_req_rdy,
    input  logic              i_req_rd,
    input  logic [CSW-1:0]    i_req_cs,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic              i_req_end,
    output logic              o_rd_vld,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_busy,
    output logic              o_sqi_sck,
    output logic [NUM_CS-1:0] o_sqi_cs_n,
    output sqi_mode_t         o_sqi_mode,
    output logic [3:0]        o_sqi_wr_data,
    input  logic [3:0]        i_sqi_rd_data
);

    localparam int unsigned ADDR_NIB = ADDR_W / 4;
    localparam int unsigned DATA_NIB = DATA_W / 4;
    localparam int unsigned MAX_A    = (ADDR_NIB > DATA_NIB) ? ADDR_NIB : DATA_NIB;
    localparam int unsigned MAX_B    = (CS_HI_CYC > DUMMY_CYC) ? CS_HI_CYC : DUMMY_CYC;
    localparam int unsigned MAX_LEN  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W    = $clog2(MAX_LEN);
    localparam int unsigned POS_W    = $clog2(DATA_W);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CSHI  = 3'd1;
    localparam logic [2:0] ST_CMD   = 3'd2;
    localparam logic [2:0] ST_ADDR  = 3'd3;
    localparam logic [2:0] ST_DUMMY = 3'd4;
    localparam logic [2:0] ST_DATA  = 3'd5;
    localparam logic [2:0] ST_HOLD  = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic [CSW-1:0]    cs_q, cs_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              last_c, req_rdy_c, accept_c, seq_c;
    logic [ADDR_W-1:0] next_addr_c, addr_sh_c;
    logic [DATA_W-1:0] wdata_sh_c;
    logic [POS_W-1:0]  dpos_c;
    logic              sck_en_c, cs_act_c, mode_out_c;
    logic [3:0]        nib_c;
    logic [NUM_CS-1:0] cs_n_c;
    logic              sck_en_lat;

    // Nibble k of a little-endian word sits at byte k/2, high nibble first.
    assign dpos_c      = POS_W'({cnt_q >> 1, ~cnt_q[0], 2'b00});
    assign next_addr_c = addr_q + ADDR_W'(DATA_W / 8);
    assign addr_sh_c   = addr_q << {cnt_q, 2'b00};
    assign wdata_sh_c  = wdata_q >> dpos_c;

    always_comb begin
        last_c = 1'b0;
        case (state_q)
            ST_CSHI:  last_c = (cnt_q == CNT_W'(CS_HI_CYC - 1));
            ST_CMD:   last_c = (cnt_q == CNT_W'(1));
            ST_ADDR:  last_c = (cnt_q == CNT_W'(ADDR_NIB - 1));
            ST_DUMMY: last_c = (cnt_q == CNT_W'(DUMMY_CYC - 1));
            ST_DATA:  last_c = (cnt_q == CNT_W'(DATA_NIB - 1));
            default:  last_c = 1'b0;
        endcase
    end

    assign req_rdy_c = (state_q == ST_IDLE) || (state_q == ST_HOLD)
                    || ((state_q == ST_DATA) && last_c);
    assign accept_c  = i_req_vld && req_rdy_c;
    assign seq_c     = (i_req_rd == rd_q) && (i_req_cs == cs_q) && (i_req_addr == next_addr_c);

    // Next-state, request latching and read reassembly.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        rd_d      = rd_q;
        cs_d      = cs_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        acc_d     = acc_q;
        rd_vld_d  = 1'b0;
        rd_data_d = rd_data_q;
        if (accept_c) begin
            rd_d    = i_req_rd;
            cs_d    = i_req_cs;
            addr_d  = i_req_addr;
            wdata_d = i_req_wdata;
        end
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept_c) state_d = ST_CSHI;
            end
            ST_CSHI: if (last_c) begin
                cnt_d   = '0;
                state_d = ST_CMD;
            end
            ST_CMD: if (last_c) begin
                cnt_d   = '0;
                state_d = ST_ADDR;
            end
            ST_ADDR: if (last_c) begin
                cnt_d   = '0;
                state_d = (rd_q && (DUMMY_CYC != 0)) ? ST_DUMMY : ST_DATA;
            end
            ST_DUMMY: if (last_c) begin
                cnt_d   = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (rd_q) acc_d[dpos_c +: 4] = i_sqi_rd_data;
                if (last_c) begin
                    cnt_d = '0;
                    if (rd_q) begin
                        rd_vld_d  = 1'b1;
                        rd_data_d = acc_d;
                    end
                    if (accept_c) state_d = seq_c ? ST_DATA : ST_CSHI;
                    else          state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                cnt_d = '0;
                if (accept_c)       state_d = seq_c ? ST_DATA : ST_CSHI;
                else if (i_req_end) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
        if (i_sqi_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            cs_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            acc_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            cs_q      <= cs_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            acc_q     <= acc_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Pin decode from registered state.
    always_comb begin
        sck_en_c   = (state_q == ST_CMD) || (state_q == ST_ADDR)
                  || (state_q == ST_DUMMY) || (state_q == ST_DATA);
        cs_act_c   = sck_en_c || (state_q == ST_HOLD);
        mode_out_c = (state_q == ST_CMD) || (state_q == ST_ADDR)
                  || (((state_q == ST_DATA) || (state_q == ST_HOLD)) && !rd_q);
        nib_c = 4'h0;
        case (state_q)
            ST_CMD:  nib_c = (cnt_q == '0) ? 4'h0 : (rd_q ? 4'h3 : 4'h2);
            ST_ADDR: nib_c = addr_sh_c[ADDR_W-1 -: 4];
            ST_DATA: nib_c = wdata_sh_c[3:0];
            default: nib_c = 4'h0;
        endcase
        cs_n_c = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (cs_act_c && (CSW'(i) == cs_q)) cs_n_c[i] = 1'b0;
        end
    end

    // Enable changes only while gck is low, so the gated SCK cannot glitch.
    always_latch begin
        if (i_sqi_rst)       sck_en_lat <= 1'b0;
        else if (!i_sqi_gck) sck_en_lat <= sck_en_c;
    end

    assign o_sqi_sck     = i_sqi_gck & sck_en_lat;
    assign o_sqi_cs_n    = cs_n_c;
    assign o_sqi_mode    = mode_out_c ? SQI_MODE_OUT : SQI_MODE_IN;
    assign o_sqi_wr_data = mode_out_c ? nib_c : 4'h0;
    assign o_req_rdy     = req_rdy_c;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_rd_vld      = rd_vld_q;
    assign o_rd_data     = rd_data_q;

endmodule
